// File: rtl/div_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : div_ctrl_pkg
//  Brief    : Shared widths, watchdog defaults and state encoding for the
//             EX-stage divider sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package div_ctrl_pkg;

  // Operand word and {remainder, quotient} double-word widths
  localparam int DC_DW    = 32;
  localparam int DC_DWORD = 2 * DC_DW;

  // Default busy-cycle budget before the operation is aborted
  localparam int DC_TIMEOUT = 48;

  // Width of the busy-cycle counter
  localparam int DC_WD_W = 6;

  // Cleared-result constants for the default operand width
  localparam logic [DC_DW-1:0]    DC_ZERO_WORD  = '0;
  localparam logic [DC_DWORD-1:0] DC_ZERO_DWORD = '0;

  // Sequencer states
  typedef enum logic [1:0] {
    DC_IDLE = 2'd0,
    DC_BUSY = 2'd1,
    DC_DONE = 2'd2
  } dc_state_e;

endpackage
`default_nettype wire

// File: rtl/div_watchdog.sv
`default_nettype none
// ============================================================================
//  Module   : div_watchdog
//  Brief    : Busy-cycle counter for the divider sequencer. Cleared when an
//             operation launches, counts while the divider is busy and flags
//             the cycle in which the budget is used up.
//  Revision : 1.0 - initial release
// ============================================================================
module div_watchdog
  import div_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DC_TIMEOUT,
  parameter int CW      = DC_WD_W
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, then saturating increment while busy
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == LIMIT);

endmodule
`default_nettype wire

// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : div_ctrl
//  Brief    : Sequences the shared iterative divider for DIV/DIVU in EX.
//             Latches operands at launch, holds the divider start level while
//             busy, stalls EX until the result returns and keeps the result
//             until EX advances so a stalled instruction never relaunches.
//             Flush or watchdog expiry abort the divider with a one-cycle
//             abandon pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DW      = DC_DW,
  parameter int TIMEOUT = DC_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_div_req,
  input  logic            ex_signed,
  input  logic [DW-1:0]   ex_opr1,
  input  logic [DW-1:0]   ex_opr2,
  input  logic            ex_adv,
  input  logic            flush,
  output logic            div_start,
  output logic            div_abandon,
  output logic            div_signed,
  output logic [DW-1:0]   div_opr1,
  output logic [DW-1:0]   div_opr2,
  input  logic            div_ready,
  input  logic [2*DW-1:0] div_res,
  output logic            ex_stall,
  output logic            res_valid,
  output logic [DW-1:0]   res_hi,
  output logic [DW-1:0]   res_lo,
  output logic            timeout_err
);

  dc_state_e     state_q, state_d;
  logic          div_start_q, div_start_d;
  logic          div_abandon_q, div_abandon_d;
  logic          div_signed_q, div_signed_d;
  logic [DW-1:0] div_opr1_q, div_opr1_d;
  logic [DW-1:0] div_opr2_q, div_opr2_d;
  logic          res_valid_q, res_valid_d;
  logic [DW-1:0] res_hi_q, res_hi_d;
  logic [DW-1:0] res_lo_q, res_lo_d;
  logic          timeout_err_q, timeout_err_d;
  logic          launch;
  logic          wd_expired;

  div_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CW      (DC_WD_W)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (launch),
    .enable  (state_q == DC_BUSY),
    .expired (wd_expired)
  );

  // Next-state and output decode; flush outranks every other input
  always_comb begin
    state_d       = state_q;
    div_start_d   = div_start_q;
    div_abandon_d = 1'b0;
    div_signed_d  = div_signed_q;
    div_opr1_d    = div_opr1_q;
    div_opr2_d    = div_opr2_q;
    res_valid_d   = res_valid_q;
    res_hi_d      = res_hi_q;
    res_lo_d      = res_lo_q;
    timeout_err_d = 1'b0;
    launch        = 1'b0;
    ex_stall      = 1'b0;

    case (state_q)
      DC_IDLE: begin
        if (flush) begin
          // A request being killed before launch still tells the divider
          div_abandon_d = ex_div_req;
          div_start_d   = 1'b0;
          res_valid_d   = 1'b0;
        end else if (ex_div_req) begin
          launch       = 1'b1;
          ex_stall     = 1'b1;
          div_signed_d = ex_signed;
          div_opr1_d   = ex_opr1;
          div_opr2_d   = ex_opr2;
          div_start_d  = 1'b1;
          state_d      = DC_BUSY;
        end
      end

      DC_BUSY: begin
        ex_stall = 1'b1;
        if (flush) begin
          div_abandon_d = 1'b1;
          div_start_d   = 1'b0;
          res_valid_d   = 1'b0;
          state_d       = DC_IDLE;
        end else if (div_ready) begin
          res_hi_d    = div_res[2*DW-1:DW];
          res_lo_d    = div_res[DW-1:0];
          res_valid_d = 1'b1;
          div_start_d = 1'b0;
          state_d     = DC_DONE;
        end else if (wd_expired) begin
          timeout_err_d = 1'b1;
          div_abandon_d = 1'b1;
          div_start_d   = 1'b0;
          state_d       = DC_IDLE;
        end
      end

      DC_DONE: begin
        // Result is parked here; a still-high request must not relaunch
        if (flush) begin
          div_abandon_d = 1'b1;
          res_valid_d   = 1'b0;
          res_hi_d      = '0;
          res_lo_d      = '0;
          state_d       = DC_IDLE;
        end else if (ex_adv) begin
          res_valid_d = 1'b0;
          res_hi_d    = '0;
          res_lo_d    = '0;
          state_d     = DC_IDLE;
        end
      end

      default: begin
        div_start_d = 1'b0;
        res_valid_d = 1'b0;
        state_d     = DC_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= DC_IDLE;
      div_start_q   <= 1'b0;
      div_abandon_q <= 1'b0;
      div_signed_q  <= 1'b0;
      div_opr1_q    <= '0;
      div_opr2_q    <= '0;
      res_valid_q   <= 1'b0;
      res_hi_q      <= '0;
      res_lo_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_start_q   <= div_start_d;
      div_abandon_q <= div_abandon_d;
      div_signed_q  <= div_signed_d;
      div_opr1_q    <= div_opr1_d;
      div_opr2_q    <= div_opr2_d;
      res_valid_q   <= res_valid_d;
      res_hi_q      <= res_hi_d;
      res_lo_q      <= res_lo_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign div_start   = div_start_q;
  assign div_abandon = div_abandon_q;
  assign div_signed  = div_signed_q;
  assign div_opr1    = div_opr1_q;
  assign div_opr2    = div_opr2_q;
  assign res_valid   = res_valid_q;
  assign res_hi      = res_hi_q;
  assign res_lo      = res_lo_q;
  assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
//  Module   : tb_div_ctrl
//  Brief    : Directed bench for div_ctrl with a simple divider stand-in and
//             an operation-level reference model compared every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_div_ctrl;

  localparam int DW      = 32;
  localparam int TIMEOUT = 48;
  localparam int LAT     = 36;

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_div_req, ex_signed, ex_adv, flush;
  logic [DW-1:0] ex_opr1, ex_opr2;
  logic          div_start, div_abandon, div_signed;
  logic [DW-1:0] div_opr1, div_opr2;
  logic          div_ready = 1'b0;
  logic [2*DW-1:0] div_res = '0;
  logic          ex_stall, res_valid, timeout_err;
  logic [DW-1:0] res_hi, res_lo;

  div_ctrl #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .ex_div_req(ex_div_req), .ex_signed(ex_signed),
    .ex_opr1(ex_opr1), .ex_opr2(ex_opr2),
    .ex_adv(ex_adv), .flush(flush),
    .div_start(div_start), .div_abandon(div_abandon), .div_signed(div_signed),
    .div_opr1(div_opr1), .div_opr2(div_opr2),
    .div_ready(div_ready), .div_res(div_res),
    .ex_stall(ex_stall), .res_valid(res_valid),
    .res_hi(res_hi), .res_lo(res_lo), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // {remainder, quotient} by plain arithmetic
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, sq, sr;
    logic [31:0] q, r;
    if (s) begin
      sa = a; sb = b;
      sq = sa / sb; sr = sa % sb;
      q = sq; r = sr;
    end else begin
      q = a / b; r = a % b;
    end
    return {r, q};
  endfunction

  // Divider stand-in: answers LAT cycles after start is seen, unless tied off
  bit tie = 1'b0;
  int fd_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (rst || !div_start) begin
      fd_cnt = 0;
      div_ready = 1'b0;
    end else begin
      fd_cnt++;
      if (!tie && fd_cnt == LAT) begin
        div_ready = 1'b1;
        div_res = ref_div(div_signed, div_opr1, div_opr2);
      end else begin
        div_ready = 1'b0;
      end
    end
    if (!div_ready) div_res = {$urandom, $urandom};
  end

  // Operation-level reference model: one operation in flight or one result parked
  bit          m_busy, m_hold;
  int          m_age;
  logic        e_start, e_abandon, e_sgn, e_valid, e_tmo;
  logic [31:0] e_op1, e_op2, e_hi, e_lo;

  always @(posedge clk) begin
    e_abandon = 1'b0;
    e_tmo = 1'b0;
    if (rst) begin
      m_busy = 0; m_hold = 0; m_age = 0;
      e_start = 0; e_sgn = 0; e_op1 = 0; e_op2 = 0;
      e_valid = 0; e_hi = 0; e_lo = 0;
    end else if (flush) begin
      if (m_busy || m_hold || ex_div_req) e_abandon = 1'b1;
      m_busy = 0; m_hold = 0;
      e_start = 0; e_valid = 0; e_hi = 0; e_lo = 0;
    end else if (m_busy) begin
      if (div_ready) begin
        {e_hi, e_lo} = ref_div(e_sgn, e_op1, e_op2);
        m_busy = 0; m_hold = 1; e_valid = 1; e_start = 0;
      end else if (m_age == TIMEOUT - 1) begin
        m_busy = 0; e_tmo = 1; e_abandon = 1; e_start = 0;
      end else begin
        m_age++;
      end
    end else if (m_hold) begin
      if (ex_adv) begin
        m_hold = 0; e_valid = 0; e_hi = 0; e_lo = 0;
      end
    end else if (ex_div_req) begin
      m_busy = 1; m_age = 0; e_start = 1;
      e_sgn = ex_signed; e_op1 = ex_opr1; e_op2 = ex_opr2;
    end
  end

  // Per-cycle comparison against the model, plus start-rise counting
  bit chk_en = 1'b0;
  int n_rises = 0;
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_start",   {63'd0, div_start},   {63'd0, e_start});
      chk("m_abandon", {63'd0, div_abandon}, {63'd0, e_abandon});
      chk("m_signed",  {63'd0, div_signed},  {63'd0, e_sgn});
      chk("m_opr1",    {32'd0, div_opr1},    {32'd0, e_op1});
      chk("m_opr2",    {32'd0, div_opr2},    {32'd0, e_op2});
      chk("m_stall",   {63'd0, ex_stall},
          {63'd0, m_busy || (!m_hold && ex_div_req && !flush)});
      chk("m_valid",   {63'd0, res_valid},   {63'd0, e_valid});
      chk("m_hi",      {32'd0, res_hi},      {32'd0, e_hi});
      chk("m_lo",      {32'd0, res_lo},      {32'd0, e_lo});
      chk("m_tmo",     {63'd0, timeout_err}, {63'd0, e_tmo});
      if (div_start && !prev_start) n_rises++;
      prev_start = div_start;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid();
    int k;
    for (k = 0; k < 200; k++) begin
      step();
      if (res_valid) break;
    end
    if (k >= 200) chk("wait_valid_bound", 64'd0, 64'd1);
  endtask

  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
    ex_signed = s; ex_opr1 = a; ex_opr2 = b; ex_div_req = 1'b1;
    step();
  endtask

  task automatic retire();
    ex_adv = 1'b1; ex_div_req = 1'b0;
    step();
    ex_adv = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ex_div_req = 0; ex_signed = 0; ex_adv = 0; flush = 0;
    ex_opr1 = 0; ex_opr2 = 0;
    step(); step();
    chk_en = 1'b1;
    chk("rst_start", {63'd0, div_start}, 64'd0);
    chk("rst_valid", {63'd0, res_valid}, 64'd0);
    chk("rst_stall", {63'd0, ex_stall}, 64'd0);
    rst = 1'b0;
    step();

    // DIVU 100/7, operands disturbed while busy, result held 4 cycles
    launch(1'b0, 32'd100, 32'd7);
    chk("t1_start_rise", {63'd0, div_start}, 64'd1);
    chk("t1_stall", {63'd0, ex_stall}, 64'd1);
    ex_opr1 = 32'hDEAD_BEEF; ex_opr2 = 32'd1; ex_signed = 1'b1;
    wait_valid();
    chk("t1_lo", {32'd0, res_lo}, 64'h0000000E);
    chk("t1_hi", {32'd0, res_hi}, 64'h00000002);
    chk("t1_start_low", {63'd0, div_start}, 64'd0);
    chk("t1_stall_low", {63'd0, ex_stall}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t1_hold_lo", {32'd0, res_lo}, 64'h0000000E);
      chk("t1_hold_start", {63'd0, div_start}, 64'd0);
    end
    retire();
    chk("t1_adv_valid", {63'd0, res_valid}, 64'd0);
    chk("t1_adv_lo", {32'd0, res_lo}, 64'd0);
    step();

    // DIV -7/2
    launch(1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_valid();
    chk("t2_lo", {32'd0, res_lo}, 64'hFFFFFFFD);
    chk("t2_hi", {32'd0, res_hi}, 64'hFFFFFFFF);
    retire();
    step();

    // Flush at busy cycle 10, then DIVU 9/3
    launch(1'b0, 32'd1000, 32'd3);
    repeat (10) step();
    flush = 1'b1;
    step();
    chk("t3_abandon", {63'd0, div_abandon}, 64'd1);
    chk("t3_start", {63'd0, div_start}, 64'd0);
    flush = 1'b0; ex_div_req = 1'b0;
    step();
    chk("t3_abandon_once", {63'd0, div_abandon}, 64'd0);
    launch(1'b0, 32'd9, 32'd3);
    wait_valid();
    chk("t3_lo", {32'd0, res_lo}, 64'd3);
    chk("t3_hi", {32'd0, res_hi}, 64'd0);
    retire();
    step();

    // Back-to-back DIVU 50/5 then 7/8
    begin
      int r0;
      r0 = n_rises;
      launch(1'b0, 32'd50, 32'd5);
      wait_valid();
      chk("t4a_lo", {32'd0, res_lo}, 64'd10);
      chk("t4a_hi", {32'd0, res_hi}, 64'd0);
      ex_adv = 1'b1; ex_opr1 = 32'd7; ex_opr2 = 32'd8;
      step();
      ex_adv = 1'b0;
      chk("t4_idle_stall", {63'd0, ex_stall}, 64'd1);
      step();
      chk("t4b_start", {63'd0, div_start}, 64'd1);
      wait_valid();
      chk("t4b_lo", {32'd0, res_lo}, 64'd0);
      chk("t4b_hi", {32'd0, res_hi}, 64'd7);
      retire();
      step();
      chk("t4_rises", 64'(n_rises - r0), 64'd2);
    end

    // div_ready and flush in the same cycle: flush wins
    launch(1'b0, 32'd20, 32'd4);
    begin
      int k;
      for (k = 0; k < 100; k++) begin
        if (div_ready) break;
        step();
      end
      if (k >= 100) chk("t5_ready_bound", 64'd0, 64'd1);
    end
    flush = 1'b1;
    step();
    chk("t5_abandon", {63'd0, div_abandon}, 64'd1);
    chk("t5_valid", {63'd0, res_valid}, 64'd0);
    flush = 1'b0; ex_div_req = 1'b0;
    step();
    chk("t5_valid_after", {63'd0, res_valid}, 64'd0);

    // Flush in IDLE without a request: no abandon
    flush = 1'b1;
    step();
    chk("t6_no_abandon", {63'd0, div_abandon}, 64'd0);
    flush = 1'b0;
    step();

    // Watchdog with the divider never answering
    tie = 1'b1;
    launch(1'b0, 32'd1, 32'd1);
    chk("t7_start", {63'd0, div_start}, 64'd1);
    begin
      int k;
      for (k = 0; k < 100; k++) begin
        step();
        if (timeout_err) break;
      end
      chk("t7_tmo_cycles", 64'(k + 1), 64'(TIMEOUT));
    end
    chk("t7_abandon", {63'd0, div_abandon}, 64'd1);
    chk("t7_start_low", {63'd0, div_start}, 64'd0);
    ex_div_req = 1'b0;
    step();
    chk("t7_tmo_once", {63'd0, timeout_err}, 64'd0);
    chk("t7_abandon_once", {63'd0, div_abandon}, 64'd0);
    tie = 1'b0;

    // Reset mid-busy, then recover with DIVU 77/7
    launch(1'b0, 32'd77, 32'd7);
    repeat (5) step();
    rst = 1'b1; ex_div_req = 1'b0;
    step();
    chk("t8_start", {63'd0, div_start}, 64'd0);
    chk("t8_abandon", {63'd0, div_abandon}, 64'd0);
    chk("t8_opr1", {32'd0, div_opr1}, 64'd0);
    chk("t8_stall", {63'd0, ex_stall}, 64'd0);
    rst = 1'b0;
    step();
    launch(1'b0, 32'd77, 32'd7);
    wait_valid();
    chk("t8_lo", {32'd0, res_lo}, 64'd11);
    retire();
    step(); step();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: actual=expired required=finished");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequences the shared iterative divider on behalf of the EX stage for DIV/DIVU.
- Latches the operands, drives the divider start/abandon handshake and stalls EX until the result is ready.
- Holds the quotient/remainder until the pipeline advances, so a stalled instruction never re-launches the divider.
- Sits between the EX stage, the HI/LO write path and the Divider instance.

Parameters:
- DW, 32, operand width; the result is 2*DW.
- TIMEOUT, 48, maximum BUSY cycles before the watchdog aborts the operation.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_div_req  in  1  EX holds a DIV/DIVU instruction (level; stays high while EX is stalled)
- ex_signed  in  1  1=DIV, 0=DIVU
- ex_opr1  in  DW  dividend (rs)
- ex_opr2  in  DW  divisor (rt)
- ex_adv  in  1  EX instruction leaves the stage this cycle
- flush  in  1  exception or branch flush kills the EX instruction
- div_start  out  1  divider start level
- div_abandon  out  1  divider abort pulse
- div_signed  out  1  latched sign mode
- div_opr1  out  DW  latched dividend
- div_opr2  out  DW  latched divisor
- div_ready  in  1  divider result valid
- div_res  in  2*DW  {remainder, quotient}
- ex_stall  out  1  stall request to the pipeline controller
- res_valid  out  1  res_hi/res_lo are valid for HI/LO write
- res_hi  out  DW  remainder
- res_lo  out  DW  quotient
- timeout_err  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset: all outputs are 0 and the state is IDLE. A mid-operation rst also drives div_abandon=0; the divider shares rst.
- States: IDLE, BUSY, DONE. They are encoded 2'd0, 2'd1, 2'd2.
- IDLE:
  - ex_div_req && !flush latches ex_opr1, ex_opr2 and ex_signed into the div_* registers.
  - It sets div_start=1 and goes to BUSY.
  - ex_stall is combinational: it is 1 in this cycle (ex_div_req && !flush && state==IDLE).
- BUSY:
  - div_start stays 1. ex_stall=1. The busy counter increments each cycle.
  - On div_ready: capture res_hi=div_res[2DW-1:DW] and res_lo=div_res[DW-1:0]. Then set res_valid=1 and div_start=0, and go to DONE.
  - The divider returns to free on the deasserted start.
- DONE:
  - ex_stall=0. res_valid and the results are held until ex_adv.
  - ex_adv → IDLE, res_valid=0 and the results are cleared to 0.
  - ex_div_req remaining high in DONE never restarts the divider.
- ex_adv while in IDLE with a new request: the new operands launch, which gives back-to-back divides. Minimum spacing is DONE→IDLE→BUSY.
- flush:
  - In any state, flush has priority over all other inputs.
  - If the state is BUSY or DONE, or IDLE with a launch in progress: div_abandon=1 for exactly one cycle, div_start=0, res_valid=0, state → IDLE.
  - Flush in IDLE with no request produces no abandon pulse.
- Watchdog:
  - The busy counter is 6-bit and resets to 0 on entering BUSY.
  - Counter reaching TIMEOUT-1 without div_ready gives timeout_err=1 and div_abandon=1, each for one cycle, and state → IDLE.
  - Nominal divider latency is about 36 cycles from start.
- Division by zero is not special-cased. The divider's result is forwarded unchanged, and HI/LO are architecturally UNPREDICTABLE.
- Simultaneous div_ready and flush in the same cycle: flush wins and no result is delivered.
- Operands are taken only at launch. Changes on ex_opr* during BUSY are ignored.

Decomposition:
- Shared package/defines holds:
  - the state encodings `DcIdle, `DcBusy, `DcDone
  - the `DWord and `DataBus widths
  - `ZeroWord and `ZeroDWord
  - the TIMEOUT default
- No sub-module is required.
- The watchdog counter may be factored out as div_watchdog (counter plus compare, cleared on BUSY entry).

Test Plan:
- DIVU 100/7 (ex_signed=0):
  - div_start rises in the cycle after the request is sampled.
  - ex_stall stays high until div_ready.
  - Then res_lo=0x0000000E, res_hi=0x00000002, res_valid=1, and div_start=0 in the next cycle.
- DIV 0xFFFFFFF9/2 (−7/2) → res_lo=0xFFFFFFFD, res_hi=0xFFFFFFFF.
- Flush at BUSY cycle 10 → div_abandon high for exactly 1 cycle, state IDLE, res_valid never asserted; a new DIVU 9/3 then gives res_lo=3, res_hi=0.
- Hold ex_adv=0 for 4 cycles after DONE while keeping ex_div_req=1 → results stay constant, div_start stays 0 (no relaunch); ex_adv=1 → IDLE with res_valid=0.
- Two back-to-back DIVU ops (50/5, then 7/8) → outputs 10/0, then 0/7, with no lost or duplicated start.
- Tie div_ready=0 → timeout_err and div_abandon pulse at BUSY cycle TIMEOUT-1; rst asserted mid-BUSY → all outputs 0 on the next edge.
